// File: rtl/maze_query_arbiter.sv
// maze_query_arbiter: shares one maze lookup port among NUM_REQ movers.
// Movers are picked round-robin (index 0 = pacman). Each grant issues one
// lookup, waits LOOKUP_LAT cycles and returns the result with a one-cycle ack.
// Optional feature: define MAZE_QUERY_CACHE_EN for a one-entry result cache
// that answers a repeated query without touching the maze port.
module maze_query_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int COORD_W    = 9,
   parameter int LOOKUP_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*COORD_W-1:0] req_x,
   input  logic [NUM_REQ*COORD_W-1:0] req_y,
   input  logic [NUM_REQ*4-1:0]       req_dir,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       rsp_collide,
   output logic [2:0]                 rsp_flag,
   output logic                       maze_valid,
   output logic [COORD_W-1:0]         maze_x,
   output logic [COORD_W-1:0]         maze_y,
   output logic [3:0]                 maze_dir,
   input  logic                       maze_collide,
   input  logic [2:0]                 maze_flag,
   output logic                       busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [3:0]         dir;
   } query_t;

   state_t                  state;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        gnt;
   logic                    bad_dir;
   logic [CNT_W-1:0]        cnt;

   query_t [NUM_REQ-1:0]    lane_q;
   query_t                  sel_q;
   logic                    sel_ok;
   logic                    any_req;
   logic [IDX_W-1:0]        gnt_idx;

   // unpack the flat per-requester buses into one query struct per lane
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign lane_q[i] = {req_x[i*COORD_W +: COORD_W],
                          req_y[i*COORD_W +: COORD_W],
                          req_dir[i*4 +: 4]};
   end

   // round-robin pick: first set req bit after the last served requester
   always_comb begin
      int               c;
      logic [IDX_W-1:0] c_idx;
      any_req = 1'b0;
      gnt_idx = '0;
      c       = 0;
      c_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         c_idx = IDX_W'(c);
         if (!any_req && req[c_idx]) begin
            any_req = 1'b1;
            gnt_idx = c_idx;
         end
      end
   end

   assign sel_q  = lane_q[gnt_idx];
   assign sel_ok = $onehot(sel_q.dir);

`ifdef MAZE_QUERY_CACHE_EN
   logic       cache_vld;
   logic       cache_collide;
   logic [2:0] cache_flag;
   logic       cache_hit;

   // maze_x/y/dir always hold the last issued lookup, so they double as the cache key
   assign cache_hit = cache_vld && ({maze_x, maze_y, maze_dir} == sel_q);
`endif

   // main FSM; every output is registered and set on entry to the state that shows it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= IDX_W'(NUM_REQ - 1);
         gnt         <= '0;
         bad_dir     <= 1'b0;
         cnt         <= '0;
         ack         <= '0;
         rsp_collide <= 1'b0;
         rsp_flag    <= 3'b000;
         maze_valid  <= 1'b0;
         maze_x      <= '0;
         maze_y      <= '0;
         maze_dir    <= 4'b0000;
         busy        <= 1'b0;
`ifdef MAZE_QUERY_CACHE_EN
         cache_vld     <= 1'b0;
         cache_collide <= 1'b0;
         cache_flag    <= 3'b000;
`endif
      end else begin
         ack        <= '0;
         maze_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt  <= gnt_idx;
                  busy <= 1'b1;
                  if (!sel_ok) begin
                     // malformed direction: burn the ISSUE slot without a lookup
                     bad_dir <= 1'b1;
                     state   <= ISSUE;
`ifdef MAZE_QUERY_CACHE_EN
                  end else if (cache_hit) begin
                     ack[gnt_idx] <= 1'b1;
                     rsp_collide  <= cache_collide;
                     rsp_flag     <= cache_flag;
                     state        <= RESP;
`endif
                  end else begin
                     bad_dir    <= 1'b0;
                     maze_valid <= 1'b1;
                     maze_x     <= sel_q.x;
                     maze_y     <= sel_q.y;
                     maze_dir   <= sel_q.dir;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (bad_dir) begin
                  ack[gnt]    <= 1'b1;
                  rsp_collide <= 1'b1;
                  rsp_flag    <= 3'b000;
                  state       <= RESP;
               end else begin
                  cnt   <= CNT_W'(LOOKUP_LAT - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  ack[gnt]    <= 1'b1;
                  rsp_collide <= maze_collide;
                  rsp_flag    <= maze_flag;
`ifdef MAZE_QUERY_CACHE_EN
                  cache_vld     <= 1'b1;
                  cache_collide <= maze_collide;
                  cache_flag    <= maze_flag;
`endif
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               ptr   <= gnt;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Self-checking bench for maze_query_arbiter: table of single queries plus
// hand-written multi-cycle sequences, all checked through ack/lookup scoreboards.
module tb_maze_query_arbiter;

   localparam int NR  = 4;
   localparam int CW  = 9;
   localparam int LAT = 2;
`ifdef MAZE_QUERY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req;
   logic [NR*CW-1:0]  req_x, req_y;
   logic [NR*4-1:0]   req_dir;
   logic [NR-1:0]     ack;
   logic              rsp_collide;
   logic [2:0]        rsp_flag;
   logic              maze_valid;
   logic [CW-1:0]     maze_x, maze_y;
   logic [3:0]        maze_dir;
   logic              maze_collide;
   logic [2:0]        maze_flag;
   logic              busy;

   maze_query_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .LOOKUP_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
      .req_dir(req_dir), .ack(ack), .rsp_collide(rsp_collide), .rsp_flag(rsp_flag),
      .maze_valid(maze_valid), .maze_x(maze_x), .maze_y(maze_y), .maze_dir(maze_dir),
      .maze_collide(maze_collide), .maze_flag(maze_flag), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // maze map model: collide depends on x parity and the D bit, flag on y
   function automatic logic [3:0] maze_fn(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                          input logic [3:0] dir);
      return {x[0] ^ dir[0], y[3:1]};
   endfunction

   // lookup model: data valid exactly LAT cycles after maze_valid, junk otherwise
   logic       mvp [LAT];
   logic [3:0] rp  [LAT];
   initial for (int i = 0; i < LAT; i++) begin mvp[i] = 1'b0; rp[i] = 4'h0; end
   always @(posedge clk) begin
      for (int i = LAT-1; i > 0; i--) begin
         mvp[i] <= mvp[i-1];
         rp[i]  <= rp[i-1];
      end
      mvp[0] <= maze_valid;
      rp[0]  <= maze_fn(maze_x, maze_y, maze_dir);
   end
   assign maze_collide = mvp[LAT-1] ? rp[LAT-1][3]   : 1'b1;
   assign maze_flag    = mvp[LAT-1] ? rp[LAT-1][2:0] : 3'b111;

   // scoreboards
   typedef struct { int idx; int t; logic c; logic [2:0] f; } ack_exp_t;
   typedef struct { int t; logic [CW-1:0] x; logic [CW-1:0] y; logic [3:0] dir; } lk_exp_t;
   ack_exp_t ack_q[$];
   lk_exp_t  lk_q[$];

   function automatic void push_exp(input int idx, input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input logic [3:0] dir, input int t, input logic c,
                                    input logic [2:0] f, input bit hit);
      if (!$onehot(dir))
         ack_q.push_back('{idx, t + 2, 1'b1, 3'b000});
      else if (CACHE && hit)
         ack_q.push_back('{idx, t + 1, c, f});
      else begin
         lk_q.push_back('{t + 1, x, y, dir});
         ack_q.push_back('{idx, t + 2 + LAT, c, f});
      end
   endfunction

   // output monitor, away from the active edge
   always @(negedge clk) begin
      ack_exp_t ea;
      lk_exp_t  el;
      if (ack !== '0) begin
         if (ack_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'h0);
         else begin
            ea = ack_q.pop_front();
            chk("ack_vec", 32'(ack), 32'(1) << ea.idx);
            chk("ack_cycle", cyc, ea.t);
            chk("rsp_collide", 32'(rsp_collide), 32'(ea.c));
            chk("rsp_flag", 32'(rsp_flag), 32'(ea.f));
         end
      end else if (ack_q.size() > 0 && ack_q[0].t < cyc) begin
         ea = ack_q.pop_front();
         chk("ack_missing", 32'(ack), 32'(1) << ea.idx);
      end
      if (maze_valid !== 1'b0) begin
         if (lk_q.size() == 0) chk("unexpected_lookup", 32'(maze_valid), 32'h0);
         else begin
            el = lk_q.pop_front();
            chk("lookup_cycle", cyc, el.t);
            chk("maze_x", 32'(maze_x), 32'(el.x));
            chk("maze_y", 32'(maze_y), 32'(el.y));
            chk("maze_dir", 32'(maze_dir), 32'(el.dir));
         end
      end else if (lk_q.size() > 0 && lk_q[0].t < cyc) begin
         el = lk_q.pop_front();
         chk("lookup_missing", 32'(maze_valid), 32'h1);
      end
   end

   task automatic drive(input int idx, input logic [CW-1:0] x, input logic [CW-1:0] y,
                        input logic [3:0] dir);
      req[idx]           = 1'b1;
      req_x[idx*CW +: CW] = x;
      req_y[idx*CW +: CW] = y;
      req_dir[idx*4 +: 4] = dir;
   endtask

   // wait until at most 'left' acks are pending; ends just after a negedge
   task automatic wait_acks(input int left);
      int n = 0;
      while ((ack_q.size() > left || (left == 0 && lk_q.size() > 0)) && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 40) chk("ack_timeout", 32'(ack_q.size()), 32'(left));
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      next_cycle();
      rst_n = 1'b0;
      req   = '0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   typedef struct {
      int            idx;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [3:0]    dir;
      logic          c;
      logic [2:0]    f;
      bit            hit;
   } vec_t;
   vec_t tbl[11];

   initial begin
      int t;
      tbl[0]  = '{0,  84, 100, 4'b0100, 1'b0, 3'b010, 1'b1};  // repeat of first query
      tbl[1]  = '{1,   7,  13, 4'b0001, 1'b0, 3'b110, 1'b0};
      tbl[2]  = '{2, 255,   6, 4'b1000, 1'b1, 3'b011, 1'b0};
      tbl[3]  = '{3, 511, 511, 4'b0010, 1'b1, 3'b111, 1'b0};
      tbl[4]  = '{1,   5,   5, 4'b0110, 1'b1, 3'b000, 1'b0};  // multi-hot
      tbl[5]  = '{2,   0,   0, 4'b0000, 1'b1, 3'b000, 1'b0};  // zero dir
      tbl[6]  = '{0,  40,   9, 4'b0001, 1'b1, 3'b100, 1'b0};
      tbl[7]  = '{0,  40,   9, 4'b0001, 1'b1, 3'b100, 1'b1};
      tbl[8]  = '{3,  40,   9, 4'b1111, 1'b1, 3'b000, 1'b0};
      tbl[9]  = '{0,  40,   9, 4'b0001, 1'b1, 3'b100, 1'b1};
      tbl[10] = '{1,  40,   9, 4'b0100, 1'b0, 3'b100, 1'b0};

      rst_n = 1'b0; req = '0; req_x = '0; req_y = '0; req_dir = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_maze_valid", 32'(maze_valid), 32'h0);
      chk("rst_maze_xy", 32'({maze_x, maze_y}), 32'h0);
      chk("rst_maze_dir", 32'(maze_dir), 32'h0);
      chk("rst_rsp", 32'({rsp_collide, rsp_flag}), 32'h0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // basic query with busy window
      drive(0, 84, 100, 4'b0100);
      t = cyc;
      push_exp(0, 84, 100, 4'b0100, t, 1'b0, 3'b010, 1'b0);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("busy_T+%0d", i), 32'(busy), 32'((i >= 1) ? 1 : 0));
      end
      next_cycle();
      req = '0;
      @(negedge clk);
      chk("busy_T+5", 32'(busy), 32'h0);
      next_cycle();

      // table of single queries
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].dir);
         push_exp(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].dir, cyc, tbl[i].c, tbl[i].f, tbl[i].hit);
         wait_acks(0);
         next_cycle();
         req = '0;
      end

      // round robin: all four, each drops after its ack
      pulse_reset();
      for (int i = 0; i < NR; i++) drive(i, 9'(100 + i), 9'(20 + 3*i), 4'b0010);
      t = cyc;
      for (int i = 0; i < NR; i++) begin
         logic [3:0] r;
         r = maze_fn(9'(100 + i), 9'(20 + 3*i), 4'b0010);
         push_exp(i, 9'(100 + i), 9'(20 + 3*i), 4'b0010, t + 5*i, r[3], r[2:0], 1'b0);
      end
      for (int k = 0; k < NR; k++) begin
         wait_acks(NR - 1 - k);
         next_cycle();
         req[k] = 1'b0;
      end
      // requesters 0 and 2 persistent -> 0,2,0,2
      drive(0, 150, 33, 4'b1000);
      drive(2, 151, 44, 4'b0001);
      t = cyc;
      for (int i = 0; i < 4; i++) begin
         logic [3:0] r;
         if (i % 2 == 0) begin
            r = maze_fn(150, 33, 4'b1000);
            push_exp(0, 150, 33, 4'b1000, t + 5*i, r[3], r[2:0], 1'b0);
         end else begin
            r = maze_fn(151, 44, 4'b0001);
            push_exp(2, 151, 44, 4'b0001, t + 5*i, r[3], r[2:0], 1'b0);
         end
      end
      wait_acks(0);
      next_cycle();
      req = '0;

      // invalid direction from requester 1, leaves pointer at 1
      drive(1, 12, 12, 4'b0110);
      push_exp(1, 12, 12, 4'b0110, cyc, 1'b1, 3'b000, 1'b0);
      wait_acks(0);
      next_cycle();
      req = '0;

      // reset during WAIT: lookup aborted, late result ignored, pointer reset
      drive(3, 70, 22, 4'b0010);
      t = cyc;
      lk_q.push_back('{t + 1, 9'd70, 9'd22, 4'b0010});
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("midrst_ack", 32'(ack), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_maze", 32'({maze_valid, maze_x, maze_y, maze_dir}), 32'h0);
      chk("midrst_rsp", 32'({rsp_collide, rsp_flag}), 32'h0);
      next_cycle();
      rst_n = 1'b1;
      repeat (4) next_cycle();
      drive(0, 60, 14, 4'b0100);
      drive(2, 61, 15, 4'b1000);
      t = cyc;
      begin
         logic [3:0] r0, r2;
         r0 = maze_fn(60, 14, 4'b0100);
         r2 = maze_fn(61, 15, 4'b1000);
         push_exp(0, 60, 14, 4'b0100, t, r0[3], r0[2:0], 1'b0);
         push_exp(2, 61, 15, 4'b1000, t + 5, r2[3], r2[2:0], 1'b0);
      end
      wait_acks(1);
      next_cycle();
      req[0] = 1'b0;
      wait_acks(0);
      next_cycle();
      req = '0;

      // inputs change after grant: latched x is used
      drive(3, 30, 12, 4'b1000);
      begin
         logic [3:0] r;
         r = maze_fn(30, 12, 4'b1000);
         push_exp(3, 30, 12, 4'b1000, cyc, r[3], r[2:0], 1'b0);
      end
      next_cycle();
      req_x[3*CW +: CW] = 9'd31;
      wait_acks(0);
      next_cycle();
      req = '0;

      repeat (4) next_cycle();
      chk("sb_ack_drained", 32'(ack_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
